// File: rtl/simd_instr_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// simd_instr_receiver
//   Collects a four-instruction command from an issuer, then launches a SIMD
//   datapath and reports completion back to the issuer.
//     LD    -> operand A address   (o_addr_0)
//     LD    -> operand B address   (o_addr_1)
//     INFO  -> {count, op}         (o_count upper half, o_op lower half)
//     STORE -> result address      (o_wr_addr)
//   Each accepted instruction is acknowledged with a one-cycle o_ack in the
//   cycle after capture. A nonzero opcode arriving out of order aborts the
//   command with a one-cycle o_err and clears the captured fields.
//   After launch, the block waits in EXEC for i_done, bounded by DONE_TIMEOUT
//   cycles (0 = no bound). On timeout it pulses o_err and still finishes.
//
// Ports
//   i_clk      sole clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_en       issuer enable/select strobe, sampled in IDLE only
//   i_instr    instruction {opcode, payload}; opcode 0 = no instruction
//   i_ack      issuer acknowledge of o_finish, sampled in FINISH only
//   i_done     datapath completion pulse, sampled in EXEC only
//   o_ack      one-cycle acknowledge per accepted instruction
//   o_busy     processor reserved (every state except IDLE)
//   o_finish   command complete, held until i_ack
//   o_start    one-cycle datapath launch pulse
//   o_err      one-cycle protocol/timeout error pulse
//   o_addr_0 / o_addr_1 / o_wr_addr / o_count / o_op   captured command
// ---------------------------------------------------------------------------
package simd_instr_pkg;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned COUNT_W = 8;
   localparam int unsigned OP_W    = 8;

   typedef enum logic [1:0] {
      INSTR_NONE  = 2'd0,
      INSTR_LD    = 2'd1,
      INSTR_INFO  = 2'd2,
      INSTR_STORE = 2'd3
   } opcode_t;

   // INFO payload carries {count, op}, so it must exactly fill an address.
   typedef struct packed {
      opcode_t           opcode;
      logic [ADDR_W-1:0] payload;
   } instr_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr_0;
      logic [ADDR_W-1:0]  addr_1;
      logic [ADDR_W-1:0]  wr_addr;
      logic [COUNT_W-1:0] count;
      logic [OP_W-1:0]    op;
   } cmd_info_t;
endpackage

module simd_instr_receiver
   import simd_instr_pkg::*;
#(
   parameter int unsigned DONE_TIMEOUT = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_en,
   input  logic [$bits(instr_t)-1:0]  i_instr,
   input  logic                       i_ack,
   input  logic                       i_done,
   output logic                       o_ack,
   output logic                       o_busy,
   output logic                       o_finish,
   output logic                       o_start,
   output logic [ADDR_W-1:0]          o_addr_0,
   output logic [ADDR_W-1:0]          o_addr_1,
   output logic [ADDR_W-1:0]          o_wr_addr,
   output logic [COUNT_W-1:0]         o_count,
   output logic [OP_W-1:0]            o_op,
   output logic                       o_err
);

   // A zero timeout still needs a 1-bit counter to keep the logic legal.
   localparam int unsigned     CNT_W  = (DONE_TIMEOUT == 0) ? 1 : $clog2(DONE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(DONE_TIMEOUT);
   localparam bit              TO_EN  = (DONE_TIMEOUT != 0);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LD1,
      WAIT_LD2,
      WAIT_INFO,
      WAIT_STORE,
      LAUNCH,
      EXEC,
      FINISH
   } state_t;

   state_t           state, state_nxt;
   cmd_info_t        info, info_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             ack_nxt, err_nxt, proto_err;
   instr_t           instr;

   assign instr   = instr_t'(i_instr);
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      info_nxt  = info;
      cnt_nxt   = cnt;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      proto_err = 1'b0;

      unique case (state)
         IDLE: begin
            if (i_en) state_nxt = WAIT_LD1;
         end
         WAIT_LD1: begin
            if (instr.opcode == INSTR_LD) begin
               info_nxt.addr_0 = instr.payload;
               ack_nxt         = 1'b1;
               state_nxt       = WAIT_LD2;
            end else if (instr.opcode != INSTR_NONE) begin
               proto_err = 1'b1;
            end
         end
         WAIT_LD2: begin
            if (instr.opcode == INSTR_LD) begin
               info_nxt.addr_1 = instr.payload;
               ack_nxt         = 1'b1;
               state_nxt       = WAIT_INFO;
            end else if (instr.opcode != INSTR_NONE) begin
               proto_err = 1'b1;
            end
         end
         WAIT_INFO: begin
            if (instr.opcode == INSTR_INFO) begin
               {info_nxt.count, info_nxt.op} = instr.payload;
               ack_nxt   = 1'b1;
               state_nxt = WAIT_STORE;
            end else if (instr.opcode != INSTR_NONE) begin
               proto_err = 1'b1;
            end
         end
         WAIT_STORE: begin
            if (instr.opcode == INSTR_STORE) begin
               info_nxt.wr_addr = instr.payload;
               ack_nxt          = 1'b1;
               state_nxt        = LAUNCH;
            end else if (instr.opcode != INSTR_NONE) begin
               proto_err = 1'b1;
            end
         end
         LAUNCH: begin
            cnt_nxt   = '0;
            state_nxt = EXEC;
         end
         EXEC: begin
            // cnt_inc counts completed EXEC cycles; i_done wins over a
            // simultaneous timeout.
            cnt_nxt = cnt_inc;
            if (i_done) begin
               state_nxt = FINISH;
            end else if (TO_EN && (cnt_inc == TO_VAL)) begin
               err_nxt   = 1'b1;
               state_nxt = FINISH;
            end
         end
         FINISH: begin
            if (i_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (proto_err) begin
         err_nxt   = 1'b1;
         info_nxt  = '0;
         state_nxt = IDLE;
      end
   end

   // Status outputs are registered from the next state so they line up with
   // the state they describe, without combinational paths to the issuer.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state    <= IDLE;
         info     <= '0;
         cnt      <= '0;
         o_ack    <= 1'b0;
         o_err    <= 1'b0;
         o_busy   <= 1'b0;
         o_start  <= 1'b0;
         o_finish <= 1'b0;
      end else begin
         state    <= state_nxt;
         info     <= info_nxt;
         cnt      <= cnt_nxt;
         o_ack    <= ack_nxt;
         o_err    <= err_nxt;
         o_busy   <= (state_nxt != IDLE);
         o_start  <= (state_nxt == LAUNCH);
         o_finish <= (state_nxt == FINISH);
      end
   end

   assign o_addr_0  = info.addr_0;
   assign o_addr_1  = info.addr_1;
   assign o_wr_addr = info.wr_addr;
   assign o_count   = info.count;
   assign o_op      = info.op;

endmodule

// File: tb/tb_simd_instr_receiver.sv
`timescale 1ns/1ps
module tb_simd_instr_receiver;
   import simd_instr_pkg::*;

   localparam int TO_MAIN = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic   rstn;
   // main instance
   logic   en, done, ack_in;
   instr_t instr;
   logic   o_ack, o_busy, o_finish, o_start, o_err;
   logic [15:0] o_addr_0, o_addr_1, o_wr_addr;
   logic [7:0]  o_count, o_op;
   // short-timeout instance
   logic   t_en, t_done, t_ack_in;
   instr_t t_instr;
   logic   t_ack, t_busy, t_finish, t_start, t_err;
   logic [15:0] t_addr_0, t_addr_1, t_wr_addr;
   logic [7:0]  t_count, t_op;

   int total = 0;
   int bad   = 0;

   simd_instr_receiver #(.DONE_TIMEOUT(TO_MAIN)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_instr(instr), .i_ack(ack_in),
      .i_done(done), .o_ack(o_ack), .o_busy(o_busy), .o_finish(o_finish),
      .o_start(o_start), .o_addr_0(o_addr_0), .o_addr_1(o_addr_1),
      .o_wr_addr(o_wr_addr), .o_count(o_count), .o_op(o_op), .o_err(o_err));

   simd_instr_receiver #(.DONE_TIMEOUT(4)) dut_to (
      .i_clk(clk), .i_rstn(rstn), .i_en(t_en), .i_instr(t_instr), .i_ack(t_ack_in),
      .i_done(t_done), .o_ack(t_ack), .o_busy(t_busy), .o_finish(t_finish),
      .o_start(t_start), .o_addr_0(t_addr_0), .o_addr_1(t_addr_1),
      .o_wr_addr(t_wr_addr), .o_count(t_count), .o_op(t_op), .o_err(t_err));

   // ---------------- reference model ----------------
   // ph: 0 idle, 1..4 waiting for k-th instruction, 5 launch, 6 exec, 7 finish
   int          ph;
   int          m_exec;
   bit          m_ack, m_err;
   logic [15:0] m_a0, m_a1, m_wr;
   logic [7:0]  m_cnt, m_op;
   opcode_t     exp_seq [4] = '{INSTR_LD, INSTR_LD, INSTR_INFO, INSTR_STORE};

   task automatic m_reset();
      ph = 0; m_exec = 0; m_ack = 0; m_err = 0;
      m_a0 = '0; m_a1 = '0; m_wr = '0; m_cnt = '0; m_op = '0;
   endtask

   task automatic m_step();
      m_ack = 0; m_err = 0;
      case (ph)
         0: if (en) ph = 1;
         1, 2, 3, 4: begin
            if (instr.opcode != INSTR_NONE) begin
               if (instr.opcode == exp_seq[ph-1]) begin
                  m_ack = 1;
                  case (ph)
                     1: m_a0 = instr.payload;
                     2: m_a1 = instr.payload;
                     3: begin m_cnt = instr.payload[15:8]; m_op = instr.payload[7:0]; end
                     default: m_wr = instr.payload;
                  endcase
                  ph = ph + 1;
               end else begin
                  m_err = 1;
                  m_a0 = '0; m_a1 = '0; m_wr = '0; m_cnt = '0; m_op = '0;
                  ph = 0;
               end
            end
         end
         5: begin ph = 6; m_exec = 0; end
         6: begin
            m_exec = m_exec + 1;
            if (done) ph = 7;
            else if (m_exec == TO_MAIN) begin m_err = 1; ph = 7; end
         end
         default: if (ack_in) ph = 0;
      endcase
   endtask

   task automatic cmp_model(input string name);
      logic [68:0] act, want;
      act  = {o_ack, o_busy, o_err, o_start, o_finish, o_addr_0, o_addr_1, o_wr_addr, o_count, o_op};
      want = {m_ack, (ph != 0), m_err, (ph == 5), (ph == 7), m_a0, m_a1, m_wr, m_cnt, m_op};
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h (ack,busy,err,start,fin,a0,a1,wr,cnt,op)",
                  name, $time, act, want);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
      end
   endtask

   function automatic instr_t mk(input opcode_t op, input logic [15:0] pl);
      instr_t r;
      r.opcode  = op;
      r.payload = pl;
      return r;
   endfunction

   task automatic drive(input logic e, input opcode_t op, input logic [15:0] pl,
                        input logic d, input logic a);
      en = e; instr = mk(op, pl); done = d; ack_in = a;
   endtask

   task automatic cyc(input string name);
      @(posedge clk);
      m_step();
      #1;
      cmp_model(name);
   endtask

   task automatic tcyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- nominal vector table ----------------
   typedef struct {
      logic        en;
      opcode_t     op;
      logic [15:0] pl;
      logic        dn;
      logic        ak;
      logic [4:0]  want;   // {ack, busy, err, start, finish}
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t v(input logic e, input opcode_t op, input logic [15:0] pl,
                              input logic d, input logic a, input logic [4:0] w);
      vec_t r;
      r.en = e; r.op = op; r.pl = pl; r.dn = d; r.ak = a; r.want = w;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acks;
      // nominal command: each instruction followed by one idle cycle,
      // i_done after 5 EXEC cycles, then i_ack
      tbl[0]  = v(1, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[1]  = v(0, INSTR_LD,    16'h0010, 0, 0, 5'b11000);
      tbl[2]  = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[3]  = v(0, INSTR_LD,    16'h0020, 0, 0, 5'b11000);
      tbl[4]  = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[5]  = v(0, INSTR_INFO,  16'h0802, 0, 0, 5'b11000);
      tbl[6]  = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[7]  = v(0, INSTR_STORE, 16'h0030, 0, 0, 5'b11010);
      tbl[8]  = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[9]  = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[10] = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[11] = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[12] = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01000);
      tbl[13] = v(0, INSTR_NONE,  16'h0000, 1, 0, 5'b01001);
      tbl[14] = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b01001);
      tbl[15] = v(0, INSTR_NONE,  16'h0000, 0, 1, 5'b00000);
      tbl[16] = v(0, INSTR_NONE,  16'h0000, 0, 0, 5'b00000);

      rstn = 1'b0;
      drive(0, INSTR_NONE, 0, 0, 0);
      t_en = 0; t_instr = mk(INSTR_NONE, 0); t_done = 0; t_ack_in = 0;
      m_reset();
      #2;
      cmp_model("reset_state");
      #10 rstn = 1'b1;

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].en, tbl[i].op, tbl[i].pl, tbl[i].dn, tbl[i].ak);
         @(posedge clk);
         m_step();
         #1;
         chk($sformatf("nominal_row%0d", i), {27'd0, o_ack, o_busy, o_err, o_start, o_finish},
             {27'd0, tbl[i].want});
      end
      chk("nom_addr0", {16'd0, o_addr_0}, 32'h10);
      chk("nom_addr1", {16'd0, o_addr_1}, 32'h20);
      chk("nom_count", {24'd0, o_count}, 32'd8);
      chk("nom_op",    {24'd0, o_op},    32'd2);
      chk("nom_wr",    {16'd0, o_wr_addr}, 32'h30);

      // ignored inputs
      drive(0, INSTR_LD,   16'h0055, 0, 0); cyc("ign_instr_idle");
      drive(0, INSTR_NONE, 16'h0000, 1, 1); cyc("ign_done_ack_idle");
      drive(1, INSTR_NONE, 16'h0000, 0, 0); cyc("ign_en");
      drive(1, INSTR_LD,   16'h0011, 0, 0); cyc("ign_en_busy_ld1");
      drive(1, INSTR_LD,   16'h0022, 0, 0); cyc("ign_en_busy_ld2");
      drive(0, INSTR_NONE, 16'h0000, 1, 0); cyc("ign_done_wait_info");
      chk("ign_done_no_finish", {31'd0, o_finish}, 32'd0);
      drive(0, INSTR_NONE, 16'h0000, 0, 1); cyc("ign_ack_wait_info");
      drive(0, INSTR_INFO, 16'h0403, 0, 0); cyc("ign_info");
      drive(0, INSTR_STORE,16'h0044, 0, 0); cyc("ign_store");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("ign_launch");
      drive(0, INSTR_NONE, 16'h0000, 1, 0); cyc("ign_done");
      drive(0, INSTR_NONE, 16'h0000, 0, 1); cyc("ign_ack");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("ign_idle");

      // out-of-order: INFO first
      drive(1, INSTR_NONE, 16'h0000, 0, 0); cyc("ooo_en");
      drive(0, INSTR_INFO, 16'h0901, 0, 0); cyc("ooo_info");
      chk("ooo_err", {31'd0, o_err}, 32'd1);
      chk("ooo_busy", {31'd0, o_busy}, 32'd0);
      chk("ooo_fields_clear", {o_addr_0, o_wr_addr}, 32'd0);
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("ooo_after");

      // reset while in EXEC
      drive(1, INSTR_NONE, 16'h0000, 0, 0); cyc("rst_en");
      drive(0, INSTR_LD,   16'h0101, 0, 0); cyc("rst_ld1");
      drive(0, INSTR_LD,   16'h0202, 0, 0); cyc("rst_ld2");
      drive(0, INSTR_INFO, 16'h0303, 0, 0); cyc("rst_info");
      drive(0, INSTR_STORE,16'h0404, 0, 0); cyc("rst_store");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("rst_launch");
      cyc("rst_exec");
      #2 rstn = 1'b0;
      #1;
      m_reset();
      cmp_model("rst_async_clear");
      #2 rstn = 1'b1;
      drive(0, INSTR_NONE, 16'h0000, 1, 0); cyc("rst_done_after");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("rst_idle");
      chk("rst_no_finish", {o_finish, o_ack, o_err, o_busy}, 32'd0);

      // back-to-back commands
      drive(1, INSTR_NONE, 16'h0000, 0, 0); cyc("b2b_en_a");
      drive(0, INSTR_LD,   16'h1000, 0, 0); cyc("b2b_a_ld1");
      drive(0, INSTR_LD,   16'h2000, 0, 0); cyc("b2b_a_ld2");
      drive(0, INSTR_INFO, 16'h1005, 0, 0); cyc("b2b_a_info");
      drive(0, INSTR_STORE,16'h3000, 0, 0); cyc("b2b_a_store");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("b2b_a_launch");
      drive(0, INSTR_NONE, 16'h0000, 1, 0); cyc("b2b_a_done");
      drive(0, INSTR_NONE, 16'h0000, 0, 1); cyc("b2b_a_ack");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("b2b_gap");
      acks = 0;
      drive(1, INSTR_NONE, 16'h0000, 0, 0); cyc("b2b_en_b");
      drive(0, INSTR_LD,   16'h1111, 0, 0); cyc("b2b_b_ld1");   acks += o_ack;
      drive(0, INSTR_LD,   16'h2222, 0, 0); cyc("b2b_b_ld2");   acks += o_ack;
      drive(0, INSTR_INFO, 16'h2007, 0, 0); cyc("b2b_b_info");  acks += o_ack;
      drive(0, INSTR_STORE,16'h3333, 0, 0); cyc("b2b_b_store"); acks += o_ack;
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("b2b_b_launch");acks += o_ack;
      drive(0, INSTR_NONE, 16'h0000, 1, 0); cyc("b2b_b_done");  acks += o_ack;
      chk("b2b_ack_count", acks, 32'd4);
      chk("b2b_fields", {o_addr_1, o_count, o_op}, 32'h2222_2007);
      drive(0, INSTR_NONE, 16'h0000, 0, 1); cyc("b2b_b_ack");
      drive(0, INSTR_NONE, 16'h0000, 0, 0); cyc("b2b_idle");

      // timeout on the DONE_TIMEOUT=4 instance
      t_en = 1; tcyc();
      t_en = 0; t_instr = mk(INSTR_LD, 16'h0a0a); tcyc();
      t_instr = mk(INSTR_LD, 16'h0b0b); tcyc();
      t_instr = mk(INSTR_INFO, 16'h0c0c); tcyc();
      t_instr = mk(INSTR_STORE, 16'h0d0d); tcyc();
      chk("to_start", {31'd0, t_start}, 32'd1);
      t_instr = mk(INSTR_NONE, 16'h0000); tcyc();
      chk("to_exec_entry", {t_start, t_err, t_finish}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tcyc();
         chk($sformatf("to_exec_cycle%0d", k), {t_err, t_finish, t_busy}, 32'd1);
      end
      tcyc();
      chk("to_err_pulse", {t_err, t_finish}, 32'd3);
      tcyc();
      chk("to_err_one_cycle", {t_err, t_finish}, 32'd1);
      t_ack_in = 1; tcyc();
      chk("to_ack_release", {t_finish, t_busy}, 32'd0);
      t_ack_in = 0;

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         int r;
         logic e;
         opcode_t op;
         e = ($urandom_range(0, 99) < 30);
         r = $urandom_range(0, 99);
         if (ph >= 1 && ph <= 4) begin
            if (r < 60)      op = exp_seq[ph-1];
            else if (r < 85) op = INSTR_NONE;
            else             op = opcode_t'($urandom_range(1, 3));
         end else begin
            op = opcode_t'($urandom_range(0, 3));
         end
         drive(e, op, 16'($urandom), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30));
         cyc("random");
         if ($urandom_range(0, 199) == 0) begin
            #2 rstn = 1'b0;
            #1;
            m_reset();
            cmp_model("random_reset");
            #1 rstn = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
